// File: rtl/alu_accumulator_datapath.sv
// Accumulator, MDR, registered ALU result and two-stage carry/zero flags for the controller.
// Optional macro ALU_OVF_EN adds a signed-overflow flag (ovFlag) with its own pending stage.
module alu_accumulator_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Reset_in,
  input  logic [3:0]       ALU_OP,
  input  logic             ALU_MUX,
  input  logic             ALU_EN,
  input  logic             MDR_WR,
  input  logic             A_WR,
  input  logic             FLAG_WR,
  input  logic [WIDTH-1:0] IR_LIT,
  input  logic [WIDTH-1:0] RAM_DOUT,
  output logic [WIDTH-1:0] RAM_DIN,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] MDR_out,
  output logic             carryFlag,
  output logic             zeroFlag
`ifdef ALU_OVF_EN
  ,
  output logic             ovFlag
`endif
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_INC  = 4'b0010;
  localparam logic [3:0] OP_DEC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_PASB = 4'b1000;
  localparam logic [3:0] OP_PASA = 4'b1001;
  localparam logic [3:0] OP_ROLC = 4'b1010;
  localparam logic [3:0] OP_RORC = 4'b1011;

  localparam logic [WIDTH:0]   ONE_WIDE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] a_reg, mdr_reg, r_reg;
  logic             c_reg, z_reg, cn_reg, zn_reg;

  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   wide_sum;
  logic [WIDTH-1:0] n_next;
  logic             cn_next, zn_next;

  always_comb begin
    operand_b = ALU_MUX ? mdr_reg : IR_LIT;
    wide_sum  = '0;
    n_next    = '0;
    cn_next   = c_reg;
    case (ALU_OP)
      OP_ADD: begin
        wide_sum = {1'b0, a_reg} + {1'b0, operand_b};
        n_next   = wide_sum[WIDTH-1:0];
        cn_next  = wide_sum[WIDTH];
      end
      // Bit WIDTH of the extended difference is the unsigned borrow.
      OP_SUB: begin
        wide_sum = {1'b0, a_reg} - {1'b0, operand_b};
        n_next   = wide_sum[WIDTH-1:0];
        cn_next  = wide_sum[WIDTH];
      end
      OP_INC: begin
        wide_sum = {1'b0, operand_b} + ONE_WIDE;
        n_next   = wide_sum[WIDTH-1:0];
        cn_next  = wide_sum[WIDTH];
      end
      OP_DEC: begin
        n_next  = operand_b - ONE;
        cn_next = (operand_b == '0);
      end
      OP_AND:  n_next = a_reg & operand_b;
      OP_OR:   n_next = a_reg | operand_b;
      OP_XOR:  n_next = a_reg ^ operand_b;
      OP_NOT:  n_next = ~operand_b;
      OP_PASB: n_next = operand_b;
      OP_PASA: n_next = a_reg;
      // Rotates go through the committed carry, not the pending one.
      OP_ROLC: begin
        n_next  = {operand_b[WIDTH-2:0], c_reg};
        cn_next = operand_b[MSB];
      end
      OP_RORC: begin
        n_next  = {c_reg, operand_b[WIDTH-1:1]};
        cn_next = operand_b[0];
      end
      default: n_next = '0;
    endcase
    zn_next = (n_next == '0);
  end

  // A_WR/FLAG_WR read the pre-edge R and pending flags, so same-edge ALU_EN is safe.
  always_ff @(posedge clk or posedge Reset_in) begin
    if (Reset_in) begin
      a_reg   <= '0;
      mdr_reg <= '0;
      r_reg   <= '0;
      cn_reg  <= 1'b0;
      zn_reg  <= 1'b0;
      c_reg   <= 1'b0;
      z_reg   <= 1'b1;
    end else begin
      if (ALU_EN) begin
        r_reg  <= n_next;
        cn_reg <= cn_next;
        zn_reg <= zn_next;
      end
      if (MDR_WR)  mdr_reg <= RAM_DOUT;
      if (A_WR)    a_reg   <= r_reg;
      if (FLAG_WR) begin
        c_reg <= cn_reg;
        z_reg <= zn_reg;
      end
    end
  end

  assign RAM_DIN   = r_reg;
  assign A_out     = a_reg;
  assign MDR_out   = mdr_reg;
  assign carryFlag = c_reg;
  assign zeroFlag  = z_reg;

`ifdef ALU_OVF_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic v_reg, vn_reg, vn_next;

  always_comb begin
    vn_next = v_reg;
    case (ALU_OP)
      OP_ADD:  vn_next = (a_reg[MSB] == operand_b[MSB]) && (n_next[MSB] != a_reg[MSB]);
      OP_SUB:  vn_next = (a_reg[MSB] != operand_b[MSB]) && (n_next[MSB] != a_reg[MSB]);
      OP_INC:  vn_next = (operand_b == MAX_POS);
      OP_DEC:  vn_next = (operand_b == MIN_NEG);
      default: vn_next = v_reg;
    endcase
  end

  always_ff @(posedge clk or posedge Reset_in) begin
    if (Reset_in) begin
      vn_reg <= 1'b0;
      v_reg  <= 1'b0;
    end else begin
      if (ALU_EN)  vn_reg <= vn_next;
      if (FLAG_WR) v_reg  <= vn_reg;
    end
  end

  assign ovFlag = v_reg;
`endif

endmodule

// File: tb/tb_alu_accumulator_datapath.sv
// Directed bench for alu_accumulator_datapath: vector table plus hand-written pipeline/reset sequences.
// Build with ALU_OVF_EN defined to also exercise ovFlag.
module tb_alu_accumulator_datapath;
  localparam int W = 8;

  localparam logic [3:0] EN_NONE = 4'b0000;
  localparam logic [3:0] EN_FLAG = 4'b0001;
  localparam logic [3:0] EN_A    = 4'b0010;
  localparam logic [3:0] EN_MDR  = 4'b0100;
  localparam logic [3:0] EN_ALU  = 4'b1000;

  logic         clk = 1'b0;
  logic         Reset_in = 1'b1;
  logic [3:0]   ALU_OP = '0;
  logic         ALU_MUX = 1'b0;
  logic         ALU_EN = 1'b0;
  logic         MDR_WR = 1'b0;
  logic         A_WR = 1'b0;
  logic         FLAG_WR = 1'b0;
  logic [W-1:0] IR_LIT = '0;
  logic [W-1:0] RAM_DOUT = '0;
  logic [W-1:0] RAM_DIN, A_out, MDR_out;
  logic         carryFlag, zeroFlag;
`ifdef ALU_OVF_EN
  logic         ovFlag;
`endif

  int checks = 0;
  int failures = 0;

  alu_accumulator_datapath #(.WIDTH(W)) dut (
    .clk(clk), .Reset_in(Reset_in), .ALU_OP(ALU_OP), .ALU_MUX(ALU_MUX),
    .ALU_EN(ALU_EN), .MDR_WR(MDR_WR), .A_WR(A_WR), .FLAG_WR(FLAG_WR),
    .IR_LIT(IR_LIT), .RAM_DOUT(RAM_DOUT), .RAM_DIN(RAM_DIN), .A_out(A_out),
    .MDR_out(MDR_out), .carryFlag(carryFlag), .zeroFlag(zeroFlag)
`ifdef ALU_OVF_EN
    , .ovFlag(ovFlag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] n;
    logic         c;
    logic         z;
    logic         v;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of control, wait past the edge, then drop the enables.
  task automatic step(input logic [3:0] op, input logic mux, input logic [W-1:0] lit,
                      input logic [3:0] en);
    ALU_OP  = op;
    ALU_MUX = mux;
    IR_LIT  = lit;
    {ALU_EN, MDR_WR, A_WR, FLAG_WR} = en;
    @(posedge clk);
    #1;
    {ALU_EN, MDR_WR, A_WR, FLAG_WR} = EN_NONE;
  endtask

  task automatic load_a(input logic [W-1:0] val);
    step(4'b1000, 1'b0, val, EN_ALU);
    step(4'b1000, 1'b0, val, EN_A);
  endtask

  initial begin
    //                op     a      b      cin   n      c     z     v
    vecs[0]  = '{4'h0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{4'h1, 8'h10, 8'h10, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'h1, 8'h05, 8'h10, 1'b0, 8'hF5, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'h1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{4'h2, 8'h12, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{4'h2, 8'h12, 8'h7F, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{4'h3, 8'h12, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'h3, 8'h12, 8'h80, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{4'h4, 8'hA5, 8'h0F, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'h5, 8'hA0, 8'h05, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'h6, 8'h3C, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{4'h7, 8'h00, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'h8, 8'h11, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'h9, 8'hC3, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'hA, 8'h00, 8'h80, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{4'hB, 8'h00, 8'h01, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{4'hA, 8'h00, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{4'hB, 8'h00, 8'h02, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{4'hC, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{4'hF, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

    // Power-up reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_A", A_out, 8'h00);
    chk("rst_MDR", MDR_out, 8'h00);
    chk("rst_R", RAM_DIN, 8'h00);
    chk("rst_C", {7'd0, carryFlag}, 8'd0);
    chk("rst_Z", {7'd0, zeroFlag}, 8'd1);
`ifdef ALU_OVF_EN
    chk("rst_V", {7'd0, ovFlag}, 8'd0);
`endif
    Reset_in = 1'b0;
    $display("reset: A=%h MDR=%h R=%h C=%b Z=%b", A_out, MDR_out, RAM_DIN, carryFlag, zeroFlag);

    for (int i = 0; i < NV; i++) begin
      // INC of FF/00 commits a known carry (and V=0) before the operation under test.
      step(4'b0010, 1'b0, vecs[i].c_in ? 8'hFF : 8'h00, EN_ALU);
      step(4'b0010, 1'b0, 8'h00, EN_FLAG);
      load_a(vecs[i].a);
      step(vecs[i].op, 1'b0, vecs[i].b, EN_ALU);
      chk($sformatf("v%0d_R", i), RAM_DIN, vecs[i].n);
      chk($sformatf("v%0d_A_held", i), A_out, vecs[i].a);
      chk($sformatf("v%0d_C_held", i), {7'd0, carryFlag}, {7'd0, vecs[i].c_in});
      step(4'b1000, 1'b0, 8'h00, EN_A | EN_FLAG);
      chk($sformatf("v%0d_A", i), A_out, vecs[i].n);
      chk($sformatf("v%0d_C", i), {7'd0, carryFlag}, {7'd0, vecs[i].c});
      chk($sformatf("v%0d_Z", i), {7'd0, zeroFlag}, {7'd0, vecs[i].z});
`ifdef ALU_OVF_EN
      chk($sformatf("v%0d_V", i), {7'd0, ovFlag}, {7'd0, vecs[i].v});
`endif
      $display("vec %0d op=%h a=%h b=%h cin=%b -> A=%h C=%b Z=%b",
               i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c_in, A_out, carryFlag, zeroFlag);
    end

    // SUB with MDR operand: zero result, then borrow.
    RAM_DOUT = 8'h10;
    step(4'b0000, 1'b0, 8'h00, EN_MDR);
    chk("mdr_load", MDR_out, 8'h10);
    load_a(8'h10);
    step(4'b0001, 1'b1, 8'hEE, EN_ALU);
    step(4'b0000, 1'b0, 8'h00, EN_A | EN_FLAG);
    chk("sub_mdr_A", A_out, 8'h00);
    chk("sub_mdr_C", {7'd0, carryFlag}, 8'd0);
    chk("sub_mdr_Z", {7'd0, zeroFlag}, 8'd1);
    load_a(8'h05);
    step(4'b0001, 1'b1, 8'hEE, EN_ALU);
    step(4'b0000, 1'b0, 8'h00, EN_A | EN_FLAG);
    chk("sub_brw_A", A_out, 8'hF5);
    chk("sub_brw_C", {7'd0, carryFlag}, 8'd1);
    $display("sub via MDR: A=%h C=%b Z=%b", A_out, carryFlag, zeroFlag);

    // MDR_WR and ALU_EN together: operand is the old MDR.
    RAM_DOUT = 8'h99;
    step(4'b1000, 1'b1, 8'h00, EN_ALU | EN_MDR);
    chk("mdr_same_R", RAM_DIN, 8'h10);
    chk("mdr_same_MDR", MDR_out, 8'h99);
    $display("mdr+alu: R=%h MDR=%h", RAM_DIN, MDR_out);

    // Register destination: INC of MDR=FF, flags only.
    RAM_DOUT = 8'hFF;
    step(4'b0000, 1'b0, 8'h00, EN_MDR);
    step(4'b0010, 1'b1, 8'h00, EN_ALU);
    step(4'b0000, 1'b0, 8'h00, EN_FLAG);
    chk("regdst_R", RAM_DIN, 8'h00);
    chk("regdst_C", {7'd0, carryFlag}, 8'd1);
    chk("regdst_Z", {7'd0, zeroFlag}, 8'd1);
    chk("regdst_A", A_out, 8'hF5);
    $display("reg dest: RAM_DIN=%h C=%b Z=%b A=%h", RAM_DIN, carryFlag, zeroFlag, A_out);

    // ALU_EN with A_WR commits old R; ALU_EN with FLAG_WR commits old pending flags.
    step(4'b1000, 1'b0, 8'h33, EN_ALU);
    step(4'b1000, 1'b0, 8'h44, EN_ALU | EN_A);
    chk("simul_A", A_out, 8'h33);
    chk("simul_R", RAM_DIN, 8'h44);
    step(4'b0010, 1'b0, 8'hFF, EN_ALU | EN_FLAG);
    chk("simul_Z_old", {7'd0, zeroFlag}, 8'd0);
    step(4'b0000, 1'b0, 8'h00, EN_FLAG);
    chk("simul_Z_new", {7'd0, zeroFlag}, 8'd1);
    chk("simul_C_new", {7'd0, carryFlag}, 8'd1);
    $display("simultaneous: A=%h R=%h Z=%b", A_out, RAM_DIN, zeroFlag);

    // Asynchronous reset mid-operation, with all enables held high.
    load_a(8'h55);
    chk("pre_rst_A", A_out, 8'h55);
    ALU_OP = 4'b1000; ALU_MUX = 1'b0; IR_LIT = 8'hAA; RAM_DOUT = 8'h77;
    {ALU_EN, MDR_WR, A_WR, FLAG_WR} = 4'b1111;
    #3;
    Reset_in = 1'b1;
    #1;
    chk("arst_A", A_out, 8'h00);
    chk("arst_MDR", MDR_out, 8'h00);
    chk("arst_R", RAM_DIN, 8'h00);
    chk("arst_C", {7'd0, carryFlag}, 8'd0);
    chk("arst_Z", {7'd0, zeroFlag}, 8'd1);
    @(posedge clk);
    #1;
    chk("arst_hold_A", A_out, 8'h00);
    chk("arst_hold_MDR", MDR_out, 8'h00);
    Reset_in = 1'b0;
    {ALU_EN, MDR_WR, A_WR, FLAG_WR} = EN_NONE;
    step(4'b0000, 1'b0, 8'h00, EN_FLAG | EN_A);
    chk("post_rst_Z", {7'd0, zeroFlag}, 8'd0);
    chk("post_rst_C", {7'd0, carryFlag}, 8'd0);
    chk("post_rst_A", A_out, 8'h00);
    $display("mid-op reset: A=%h MDR=%h C=%b Z=%b", A_out, MDR_out, carryFlag, zeroFlag);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
